// File: rtl/exh_harness_pkg.sv
// -----------------------------------------------------------------------------
// exh_harness_pkg
// Shared types and helpers for the exhaustive-stimulus / MISR harness.
//   harness_state_e : harness FSM states (IDLE/SETTLE/CAPTURE/DONE)
//   DEFAULT_POLY    : default MISR feedback polynomial (CRC-32)
//   DEFAULT_SEED    : default signature value loaded at run start
//   misr_step()     : one MISR update on a 32-bit container; callers keep the
//                     low 'width' bits of the result.
// -----------------------------------------------------------------------------
package exh_harness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } harness_state_e;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'hFFFF_FFFF;

  // Shift left, fold the outgoing MSB (bit width-1) back through poly and mix
  // in the response word. Bits at and above 'width' are don't-care garbage
  // that the caller drops.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] resp,
                                            input logic [31:0] poly,
                                            input int unsigned width);
    logic [31:0] msb_mask;
    logic        fb;
    msb_mask = 32'h1 << (width - 1);
    fb       = |(sig & msb_mask);
    return (sig << 1) ^ (fb ? poly : 32'h0) ^ resp;
  endfunction

endpackage

// File: rtl/exh_stim_misr_collector_misr_reg.sv
// -----------------------------------------------------------------------------
// misr_reg
// SIG_W-bit multiple-input signature register.
//   clk, rst_n  : clock / asynchronous active-low reset (loads SEED)
//   load_seed   : synchronous load of SEED (has priority over step_en)
//   step_en     : apply one MISR step with 'resp'
//   resp        : response word, already zero-extended to SIG_W
//   sig         : current signature
// -----------------------------------------------------------------------------
module misr_reg
  import exh_harness_pkg::*;
#(
  parameter int          SIG_W = 32,
  parameter logic [31:0] POLY  = DEFAULT_POLY,
  parameter logic [31:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_seed,
  input  logic             step_en,
  input  logic [SIG_W-1:0] resp,
  output logic [SIG_W-1:0] sig
);

  localparam logic [SIG_W-1:0] SEED_W = SEED[SIG_W-1:0];

  logic [31:0]      sig_w;
  logic [31:0]      resp_w;
  logic [31:0]      step_w;
  logic [SIG_W-1:0] sig_next;

  always_comb begin
    sig_w                = '0;
    sig_w[SIG_W-1:0]     = sig;
    resp_w               = '0;
    resp_w[SIG_W-1:0]    = resp;
    step_w               = misr_step(sig_w, resp_w, POLY, SIG_W);
    sig_next             = step_w[SIG_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED_W;
    end else if (load_seed) begin
      sig <= SEED_W;
    end else if (step_en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/exh_stim_misr_collector.sv
// -----------------------------------------------------------------------------
// exh_stim_misr_collector
// Drives a combinational netlist through all 2**N_IN input patterns, samples
// its outputs after SETTLE hold cycles per pattern and folds every response
// into a MISR. The final signature is offered on a valid/ready port.
//
// Ports:
//   clk, rst_n   : clock (rising edge) / asynchronous active-low reset
//   start_i      : start pulse, only looked at in IDLE
//   busy_o       : high in SETTLE, CAPTURE and DONE
//   stim_o       : current pattern for the netlist inputs (x0 = bit 0)
//   resp_i       : netlist outputs (f1 = bit 0)
//   pat_cnt_o    : patterns captured in this run
//   sig_valid_o  : signature available
//   sig_ready_i  : consumer accepts the signature
//   sig_o        : MISR signature
//   golden_i     : expected signature      (only with GOLDEN_CMP_EN)
//   match_o      : final signature==golden (only with GOLDEN_CMP_EN)
//
// Build option: define GOLDEN_CMP_EN to add golden_i/match_o and the
// comparator; without it those ports do not exist.
//
// Handshake: the signature transfers on a rising edge where sig_valid_o and
// sig_ready_i are both high. sig_valid_o is only raised in DONE and stays high
// with sig_o/pat_cnt_o frozen until that transfer; sig_ready_i is ignored in
// every other state.
// -----------------------------------------------------------------------------
module exh_stim_misr_collector
  import exh_harness_pkg::*;
#(
  parameter int          N_IN   = 2,
  parameter int          N_OUT  = 18,
  parameter int          SIG_W  = 32,
  parameter logic [31:0] POLY   = DEFAULT_POLY,
  parameter logic [31:0] SEED   = DEFAULT_SEED,
  parameter int          SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic             busy_o,
  output logic [N_IN-1:0]  stim_o,
  input  logic [N_OUT-1:0] resp_i,
  output logic [N_IN:0]    pat_cnt_o,
  output logic             sig_valid_o,
  input  logic             sig_ready_i,
  output logic [SIG_W-1:0] sig_o
`ifdef GOLDEN_CMP_EN
  ,
  input  logic [SIG_W-1:0] golden_i,
  output logic             match_o
`endif
);

  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
  localparam bit              NO_SETTLE  = (SETTLE == 0);
  localparam logic [N_IN-1:0] LAST_PAT   = '1;

  // After starting a pattern the FSM either waits out the hold time or, with
  // no hold configured, samples immediately.
  localparam harness_state_e PAT_ENTRY = NO_SETTLE ? ST_CAPTURE : ST_SETTLE;

  harness_state_e   state;
  logic [N_IN-1:0]  pattern;
  logic [3:0]       settle_cnt;
  logic [SIG_W-1:0] resp_ext;
  logic             load_seed;
  logic             step_en;
  logic             last_capture;

  always_comb begin
    resp_ext            = '0;
    resp_ext[N_OUT-1:0] = resp_i;
  end

  assign load_seed    = (state == ST_IDLE) && start_i;
  assign step_en      = (state == ST_CAPTURE);
  assign last_capture = step_en && (pattern == LAST_PAT);
  assign stim_o       = pattern;

  misr_reg #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_seed (load_seed),
    .step_en   (step_en),
    .resp      (resp_ext),
    .sig       (sig_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pattern     <= '0;
      settle_cnt  <= '0;
      pat_cnt_o   <= '0;
      busy_o      <= 1'b0;
      sig_valid_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            pattern    <= '0;
            pat_cnt_o  <= '0;
            settle_cnt <= SETTLE_CNT;
            busy_o     <= 1'b1;
            state      <= PAT_ENTRY;
          end
        end
        ST_SETTLE: begin
          // settle_cnt counts the remaining hold cycles including this one.
          if (settle_cnt <= 4'd1) begin
            state <= ST_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_CAPTURE: begin
          pat_cnt_o <= pat_cnt_o + 1'b1;
          // Terminal test happens before the increment so pattern never wraps.
          if (pattern == LAST_PAT) begin
            sig_valid_o <= 1'b1;
            state       <= ST_DONE;
          end else begin
            pattern    <= pattern + 1'b1;
            settle_cnt <= SETTLE_CNT;
            state      <= PAT_ENTRY;
          end
        end
        ST_DONE: begin
          if (sig_ready_i) begin
            sig_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GOLDEN_CMP_EN
  // The compare uses the value the MISR is about to take on the final
  // capture edge, so match_o is valid in the same cycle as sig_valid_o.
  logic [31:0] cmp_sig_w;
  logic [31:0] cmp_resp_w;
  logic [31:0] cmp_next_w;
  logic        final_match;

  always_comb begin
    cmp_sig_w              = '0;
    cmp_sig_w[SIG_W-1:0]   = sig_o;
    cmp_resp_w             = '0;
    cmp_resp_w[SIG_W-1:0]  = resp_ext;
    cmp_next_w             = misr_step(cmp_sig_w, cmp_resp_w, POLY, SIG_W);
    final_match            = (cmp_next_w[SIG_W-1:0] == golden_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_o <= 1'b0;
    end else if (load_seed) begin
      match_o <= 1'b0;
    end else if (last_capture) begin
      match_o <= final_match;
    end
  end
`else
  // Without the comparator the final-capture strobe has no consumer.
  logic unused_last_capture;
  assign unused_last_capture = last_capture;
`endif

endmodule

// File: tb/tb_exh_stim_misr_collector.sv
// -----------------------------------------------------------------------------
// tb_exh_stim_misr_collector
// Three harness instances:
//   dut_a : N_IN=2, N_OUT=2, SIG_W=4, POLY=3, SEED=0, SETTLE=1; resp is
//           either 2'b01 (constant one) or stim loopback
//   dut_b : same width, N_OUT=1, SETTLE=0, resp=0, ready held high
//   dut_c : default widths/POLY/SEED, SETTLE=1, resp=0
// Expected signatures are worked out by hand:
//   a, resp=1    : 0 -> 1 -> 3 -> 7 -> F
//   a, loopback  : 0 -> 0 -> 1 -> 0 -> 3
//   c, resp=0    : FFFFFFFF -> FB3EE249 -> F2BCD925 -> E1B8AFFD -> C7B0424D
// -----------------------------------------------------------------------------
module tb_exh_stim_misr_collector;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- dut_a ----------------
  logic       start_a, ready_a, loop_a, valid_a, busy_a, match_a;
  logic [1:0] stim_a, resp_a;
  logic [2:0] pat_a;
  logic [3:0] sig_a, golden_a;
  assign resp_a = loop_a ? stim_a : 2'b01;

  exh_stim_misr_collector #(
    .N_IN(2), .N_OUT(2), .SIG_W(4), .POLY(32'h3), .SEED(32'h0), .SETTLE(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .busy_o(busy_a),
    .stim_o(stim_a), .resp_i(resp_a), .pat_cnt_o(pat_a),
    .sig_valid_o(valid_a), .sig_ready_i(ready_a), .sig_o(sig_a)
`ifdef GOLDEN_CMP_EN
    , .golden_i(golden_a), .match_o(match_a)
`endif
  );

  // ---------------- dut_b ----------------
  logic       start_b, ready_b, valid_b, busy_b, match_b;
  logic [1:0] stim_b;
  logic [0:0] resp_b;
  logic [2:0] pat_b;
  logic [3:0] sig_b, golden_b;
  assign resp_b = 1'b0;

  exh_stim_misr_collector #(
    .N_IN(2), .N_OUT(1), .SIG_W(4), .POLY(32'h3), .SEED(32'h0), .SETTLE(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .busy_o(busy_b),
    .stim_o(stim_b), .resp_i(resp_b), .pat_cnt_o(pat_b),
    .sig_valid_o(valid_b), .sig_ready_i(ready_b), .sig_o(sig_b)
`ifdef GOLDEN_CMP_EN
    , .golden_i(golden_b), .match_o(match_b)
`endif
  );

  // ---------------- dut_c ----------------
  logic        start_c, ready_c, valid_c, busy_c, match_c;
  logic [1:0]  stim_c;
  logic [17:0] resp_c;
  logic [2:0]  pat_c;
  logic [31:0] sig_c, golden_c;
  assign resp_c = 18'h0;

  exh_stim_misr_collector #(
    .N_IN(2), .N_OUT(18), .SIG_W(32), .SETTLE(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .start_i(start_c), .busy_o(busy_c),
    .stim_o(stim_c), .resp_i(resp_c), .pat_cnt_o(pat_c),
    .sig_valid_o(valid_c), .sig_ready_i(ready_c), .sig_o(sig_c)
`ifdef GOLDEN_CMP_EN
    , .golden_i(golden_c), .match_o(match_c)
`endif
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       loop;
    int         ready_dly;
    logic       restart;
    logic [3:0] exp_sig;
    logic [3:0] golden;
    logic       exp_match;
  } run_vec_t;

  run_vec_t vecs[4];

  // One full dut_a run, sampled on falling edges. Sample k is taken after
  // the k-th rising edge following the start edge.
  task automatic run_a(input run_vec_t v, input int idx);
    loop_a   = v.loop;
    golden_a = v.golden;
    ready_a  = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("a%0d_stim_k%0d", idx, k), 32'(stim_a), 32'(k / 2));
      check($sformatf("a%0d_valid_k%0d", idx, k), 32'(valid_a), 32'h0);
      check($sformatf("a%0d_busy_k%0d", idx, k), 32'(busy_a), 32'h1);
`ifdef GOLDEN_CMP_EN
      if (k == 0) check($sformatf("a%0d_match_cleared", idx), 32'(match_a), 32'h0);
`endif
      start_a = v.restart && (k == 3);
      @(negedge clk);
    end
    start_a = 1'b0;
    check($sformatf("a%0d_done_valid", idx), 32'(valid_a), 32'h1);
    check($sformatf("a%0d_done_sig", idx), 32'(sig_a), 32'(v.exp_sig));
    check($sformatf("a%0d_done_cnt", idx), 32'(pat_a), 32'h4);
`ifdef GOLDEN_CMP_EN
    check($sformatf("a%0d_match", idx), 32'(match_a), 32'(v.exp_match));
`endif
    for (int d = 0; d < v.ready_dly; d++) begin
      @(negedge clk);
      check($sformatf("a%0d_hold_valid_d%0d", idx, d), 32'(valid_a), 32'h1);
      check($sformatf("a%0d_hold_sig_d%0d", idx, d), 32'(sig_a), 32'(v.exp_sig));
    end
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    check($sformatf("a%0d_idle_valid", idx), 32'(valid_a), 32'h0);
    check($sformatf("a%0d_idle_busy", idx), 32'(busy_a), 32'h0);
    check($sformatf("a%0d_idle_sig", idx), 32'(sig_a), 32'(v.exp_sig));
    check($sformatf("a%0d_idle_cnt", idx), 32'(pat_a), 32'h4);
    check($sformatf("a%0d_idle_stim", idx), 32'(stim_a), 32'h3);
  endtask

  // ---------------- test ----------------
  initial begin
    int n;
    vecs[0] = '{loop: 1'b0, ready_dly: 5, restart: 1'b1, exp_sig: 4'hF, golden: 4'hF, exp_match: 1'b1};
    vecs[1] = '{loop: 1'b1, ready_dly: 0, restart: 1'b0, exp_sig: 4'h3, golden: 4'h3, exp_match: 1'b1};
    vecs[2] = '{loop: 1'b1, ready_dly: 2, restart: 1'b1, exp_sig: 4'h3, golden: 4'h2, exp_match: 1'b0};
    vecs[3] = '{loop: 1'b0, ready_dly: 1, restart: 1'b0, exp_sig: 4'hF, golden: 4'h0, exp_match: 1'b0};

    start_a = 0; ready_a = 0; loop_a = 0; golden_a = 0;
    start_b = 0; ready_b = 1; golden_b = 4'h0;
    start_c = 0; ready_c = 0; golden_c = 32'hC7B0_424D;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_a_stim", 32'(stim_a), 32'h0);
    check("rst_a_sig", 32'(sig_a), 32'h0);
    check("rst_a_cnt", 32'(pat_a), 32'h0);
    check("rst_a_valid", 32'(valid_a), 32'h0);
    check("rst_a_busy", 32'(busy_a), 32'h0);
    check("rst_c_sig", sig_c, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven dut_a runs
    for (int i = 0; i < 4; i++) run_a(vecs[i], i);

    // SETTLE=0: one cycle per pattern, ready already high -> 1-cycle valid
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b_stim_k%0d", k), 32'(stim_b), 32'(k));
      check($sformatf("b_valid_k%0d", k), 32'(valid_b), 32'h0);
      @(negedge clk);
    end
    check("b_done_valid", 32'(valid_b), 32'h1);
    check("b_done_sig", 32'(sig_b), 32'h0);
    check("b_done_cnt", 32'(pat_b), 32'h4);
`ifdef GOLDEN_CMP_EN
    check("b_match", 32'(match_b), 32'h1);
`endif
    @(negedge clk);
    check("b_valid_one_cycle", 32'(valid_b), 32'h0);
    check("b_idle_busy", 32'(busy_b), 32'h0);

    // default 32-bit configuration, bounded wait for valid
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    n = 0;
    while (!valid_c && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("c_latency", 32'(n), 32'h8);
    check("c_sig", sig_c, 32'hC7B0_424D);
    check("c_cnt", 32'(pat_c), 32'h4);
`ifdef GOLDEN_CMP_EN
    check("c_match", 32'(match_c), 32'h1);
`endif
    ready_c = 1'b1;
    @(negedge clk);
    ready_c = 1'b0;
    check("c_idle_valid", 32'(valid_c), 32'h0);

    // asynchronous reset in the SETTLE phase of pattern 2
    loop_a  = 1'b1;
    start_a = 1'b1;
    start_c = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_c = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_pre_stim", 32'(stim_a), 32'h2);
    check("mid_pre_sig", 32'(sig_a), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stim", 32'(stim_a), 32'h0);
    check("mid_rst_sig", 32'(sig_a), 32'h0);
    check("mid_rst_busy", 32'(busy_a), 32'h0);
    check("mid_rst_valid", 32'(valid_a), 32'h0);
    check("mid_rst_cnt", 32'(pat_a), 32'h0);
    check("mid_rst_c_sig", sig_c, 32'hFFFF_FFFF);
    check("mid_rst_c_busy", 32'(busy_c), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_a(vecs[1], 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
